mem_stage: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Consumes execute results (we, waddr, wdata, plus opcode/funct3/rd carried forward) and performs loads and stores over a byte-wide memory port, one byte per handshake.
- Assembles and sign- or zero-extends load data, passes ALU results through, and drives the writeback register.
- Raises stall_req while a multi-byte access is in flight.

---
 rtl/mem_stage_pkg.sv | 43 ++++
 rtl/mem_stage_load_ext.sv | 28 ++
 rtl/mem_stage.sv | 204 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory-access stage: opcode and funct3 constants,
// FSM state encoding, legacy value constants and small decode helpers.
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  // Legacy value constants kept for compatibility with surrounding pipeline code.
  localparam logic        True_v   = 1'b1;
  localparam logic        False_v  = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Opcodes that need the memory port; everything else passes through.
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // funct3 access size / sign encodings.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OPC_LOAD) || (op == OPC_STORE);
  endfunction

  // Index of the final byte of an access. Size comes from funct3[1:0] only,
  // so the reserved encoding 2'b11 behaves as a word.
  function automatic logic [1:0] last_byte_idx(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// -----------------------------------------------------------------------------
// mem_load_ext
// Combinational sign/zero extension of the assembled load word by funct3.
//   i_funct3 : access size and sign (B, H, W, BU, HU; reserved 011 acts as W)
//   i_word   : little-endian assembled bytes, valid low bytes only
//   o_data   : extended writeback value
// -----------------------------------------------------------------------------
module mem_load_ext
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [31:0]     i_word,
  output logic [XLEN-1:0] o_data
);

  always_comb begin
    case (i_funct3)
      F3_B:    o_data = XLEN'($signed(i_word[7:0]));
      F3_H:    o_data = XLEN'($signed(i_word[15:0]));
      F3_BU:   o_data = XLEN'(i_word[7:0]);
      F3_HU:   o_data = XLEN'(i_word[15:0]);
      default: o_data = XLEN'($signed(i_word));
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage. ALU results pass straight to writeback in one
// cycle; loads and stores are serialised over a byte-wide memory port, one
// byte per req/ack handshake, with stall_req holding upstream meanwhile.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   rdy                 global enable; low freezes all state and outputs
//   opcode_in..wdata_in execute-stage results (addr_in is ALU result for ALU ops)
//   mem_req/we/addr/dout, mem_din/ack   byte memory port
//   we_out/waddr_out/wdata_out          writeback register
//   stall_req           combinational upstream freeze request
//   misalign_o          (only with MEM_MISALIGN_TRAP_EN) one-cycle trap pulse
//
// Build option: define MEM_MISALIGN_TRAP_EN to reject misaligned H/W accesses
// in IDLE instead of performing them byte-wise.
// -----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [6:0]        opcode_in,
  input  logic [2:0]        funct3_in,
  input  logic              we_in,
  input  logic [RA_W-1:0]   rd_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [XLEN-1:0]   wdata_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  input  logic              mem_ack,
  output logic              we_out,
  output logic [RA_W-1:0]   waddr_out,
  output logic [XLEN-1:0]   wdata_out,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalign_o,
`endif
  output logic              stall_req
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_sdata;
  logic [2:0]          r_funct3;
  logic [RA_W-1:0]     r_rd;
  logic                r_store;
  logic [1:0]          r_k;
  logic [31:0]         r_asm;

  logic                w_is_mem;
  logic                w_misalign;
  logic                w_start;
  logic                w_ack;
  logic                w_last;
  logic                w_done;
  logic [31:0]         w_asm_nxt;
  logic [XLEN-1:0]     w_load_data;

  assign w_is_mem = is_mem_op(opcode_in);

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misalign;

  assign w_misalign = w_is_mem &&
                      (((funct3_in[1:0] == 2'b01) && addr_in[0]) ||
                       (funct3_in[1] && (addr_in[1:0] != 2'b00)));
  assign misalign_o = r_misalign;
`else
  assign w_misalign = False_v;
`endif

  assign w_start = (r_state == ST_IDLE) && w_is_mem && !w_misalign;

  // An ack while frozen is ignored, so it must not complete a byte.
  assign w_ack  = rdy && mem_ack;
  assign w_last = (r_k == last_byte_idx(r_funct3));
  assign w_done = (r_state == ST_BUSY) && w_ack && w_last;

  // Assembly word including the byte arriving this cycle, so the final byte
  // can be written back on the same edge it is acknowledged.
  always_comb begin
    w_asm_nxt            = r_asm;
    w_asm_nxt[8*r_k +: 8] = mem_din;
  end

  mem_load_ext #(
    .XLEN (XLEN)
  ) u_load_ext (
    .i_funct3 (r_funct3),
    .i_word   (w_asm_nxt),
    .o_data   (w_load_data)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (rdy) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      r_state <= w_state_nxt;
    end
  end

  // Next state and memory-port outputs. The port is a pure function of the
  // BUSY state, so reset drops mem_req without waiting for a clock.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would infer a latch.
    w_state_nxt = r_state;
    mem_req     = False_v;
    mem_we      = False_v;
    mem_addr    = '0;
    mem_dout    = '0;
    stall_req   = False_v;
    case (r_state)
      ST_IDLE: begin
        stall_req = w_start;
        if (w_start) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        mem_req   = True_v;
        mem_we    = r_store;
        mem_addr  = r_addr + ADDR_W'(r_k);
        mem_dout  = r_sdata[8*r_k +: 8];
        stall_req = !w_done;
        if (w_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Access context, byte counter, assembly and writeback registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_sdata   <= ZeroWord;
      r_funct3  <= '0;
      r_rd      <= '0;
      r_store   <= False_v;
      r_k       <= '0;
      r_asm     <= ZeroWord;
      we_out    <= False_v;
      waddr_out <= '0;
      wdata_out <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      r_misalign <= False_v;
`endif
    end else if (rdy) begin
`ifdef MEM_MISALIGN_TRAP_EN
      r_misalign <= (r_state == ST_IDLE) && w_misalign;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_is_mem) begin
            // Bubble in writeback while the access runs (or is trapped).
            we_out <= False_v;
            if (w_start) begin
              r_addr   <= addr_in;
              r_sdata  <= wdata_in[31:0];
              r_funct3 <= funct3_in;
              r_rd     <= rd_in;
              r_store  <= (opcode_in == OPC_STORE);
              r_k      <= '0;
              r_asm    <= ZeroWord;
            end
          end else begin
            we_out    <= we_in && (rd_in != '0);
            waddr_out <= rd_in;
            wdata_out <= XLEN'(addr_in);
          end
        end
        ST_BUSY: begin
          if (w_ack) begin
            r_asm <= w_asm_nxt;
            if (w_last) begin
              if (r_store) begin
                we_out <= False_v;
              end else begin
                we_out    <= (r_rd != '0);
                waddr_out <= r_rd;
                wdata_out <= w_load_data;
              end
            end else begin
              r_k <= r_k + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed bench for mem_stage with a byte memory responder whose ack latency
// is programmable. Inputs change on the falling edge; outputs are sampled on
// the falling edge (plus a small settle delay for the responder's ack).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [6:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic        we_in;
  logic [4:0]  rd_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        mem_ack;
  logic        we_out;
  logic [4:0]  waddr_out;
  logic [31:0] wdata_out;
  logic        stall_req;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Memory model and handshake log.
  logic [7:0]  mem [0:1023];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  int          req_cnt   = 0;
  logic [31:0] log_addr [0:15];
  logic        log_we   [0:15];

  mem_stage #(
    .ADDR_W (32),
    .XLEN   (32),
    .RA_W   (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .opcode_in (opcode_in),
    .funct3_in (funct3_in),
    .we_in     (we_in),
    .rd_in     (rd_in),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .mem_ack   (mem_ack),
    .we_out    (we_out),
    .waddr_out (waddr_out),
    .wdata_out (wdata_out),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_o(misalign_o),
`endif
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  // Responder: 1 ns after each falling edge decide the ack for the coming
  // rising edge. A handshake that will commit (req, ack, rdy) is logged and,
  // for writes, applied to the memory array.
  initial begin
    mem_ack = 1'b0;
    mem_din = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (rst || !mem_req) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        mem_din = mem[mem_addr[9:0]];
        if (rdy) begin
          if (req_cnt < 16) begin
            log_addr[req_cnt] = mem_addr;
            log_we[req_cnt]   = mem_we;
          end
          req_cnt++;
          if (mem_we) mem[mem_addr[9:0]] = mem_dout;
          wait_cnt = 0;
        end
      end else begin
        mem_ack = 1'b0;
        if (rdy) wait_cnt++;
      end
    end
  end

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] wd, input logic we);
    opcode_in = op;
    funct3_in = f3;
    rd_in     = rd;
    addr_in   = a;
    wdata_in  = wd;
    we_in     = we;
  endtask

  task automatic drive_nop();
    drive(7'b0010011, 3'b000, 5'd0, 32'h0, 32'h0, 1'b0);
  endtask

  // Wait for stall_req to drop (final ack cycle), then retire the op upstream.
  task automatic wait_done(output int cycles, output bit ok);
    ok     = 1'b0;
    cycles = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      #2;
      if (!stall_req) begin
        ok     = 1'b1;
        cycles = c;
        break;
      end
    end
    drive_nop();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdy = 1'b1;
    drive_nop();
    repeat (2) @(negedge clk);
    n_vec++; if (mem_req !== 1'b0)    begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_vec++; if (stall_req !== 1'b0)  begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    n_vec++; if ({we_out, waddr_out, wdata_out} !== 38'h0)
      begin n_err++; $display("FAIL reset_wb: got we=%b wa=%0d wd=%h want all 0", we_out, waddr_out, wdata_out); end
    n_vec++; if ({mem_we, mem_addr, mem_dout} !== 41'h0)
      begin n_err++; $display("FAIL reset_port: got we=%b a=%h d=%h want all 0", mem_we, mem_addr, mem_dout); end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    @(negedge clk);
    drive(7'b0110011, 3'b000, 5'd5, 32'h1234, 32'h0, 1'b1);
    #2;
    n_vec++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL alu_stall: got %b want 0", stall_req); end
    @(negedge clk);
    n_vec++; if ({we_out, waddr_out, wdata_out} !== {1'b1, 5'd5, 32'h1234})
      begin n_err++; $display("FAIL alu_wb: got we=%b wa=%0d wd=%h want 1/5/00001234", we_out, waddr_out, wdata_out); end
    drive(7'b0110011, 3'b000, 5'd0, 32'h55, 32'h0, 1'b1);
    @(negedge clk);
    n_vec++; if ({we_out, wdata_out} !== {1'b0, 32'h55})
      begin n_err++; $display("FAIL alu_rd0: got we=%b wd=%h want 0/00000055", we_out, wdata_out); end
    drive(7'b0010011, 3'b000, 5'd7, 32'h66, 32'h0, 1'b0);
    @(negedge clk);
    n_vec++; if ({we_out, waddr_out} !== {1'b0, 5'd7})
      begin n_err++; $display("FAIL alu_we0: got we=%b wa=%0d want 0/7", we_out, waddr_out); end
  endtask

  task automatic test_lw();
    int cyc; bit ok;
    mem[10'h100] = 8'h78; mem[10'h101] = 8'h56; mem[10'h102] = 8'h34; mem[10'h103] = 8'h12;
    ack_delay = 1;
    req_cnt   = 0;
    drive(7'b0000011, 3'b010, 5'd9, 32'h100, 32'h0, 1'b1);
    #2;
    n_vec++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL lw_idle_stall: got %b want 1", stall_req); end
    wait_done(cyc, ok);
    n_vec++; if (!ok || cyc != 8) begin n_err++; $display("FAIL lw_stall_len: got ok=%b cycles=%0d want 8", ok, cyc); end
    n_vec++; if (req_cnt != 4) begin n_err++; $display("FAIL lw_req_cnt: got %0d want 4", req_cnt); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (log_addr[i] !== 32'h100 + i || log_we[i] !== 1'b0)
        begin n_err++; $display("FAIL lw_req%0d: got a=%h we=%b want %h/0", i, log_addr[i], log_we[i], 32'h100 + i); end
    end
    @(negedge clk);
    n_vec++; if ({we_out, waddr_out, wdata_out} !== {1'b1, 5'd9, 32'h12345678})
      begin n_err++; $display("FAIL lw_wb: got we=%b wa=%0d wd=%h want 1/9/12345678", we_out, waddr_out, wdata_out); end
  endtask

  task automatic test_lb_lbu();
    int cyc; bit ok;
    mem[10'h010] = 8'h80; mem[10'h012] = 8'h34; mem[10'h013] = 8'h92;
    ack_delay = 0;
    drive(7'b0000011, 3'b000, 5'd3, 32'h10, 32'h0, 1'b1);
    wait_done(cyc, ok);
    n_vec++; if (!ok || cyc != 1) begin n_err++; $display("FAIL lb_len: got ok=%b cycles=%0d want 1", ok, cyc); end
    @(negedge clk);
    n_vec++; if ({we_out, waddr_out, wdata_out} !== {1'b1, 5'd3, 32'hFFFFFF80})
      begin n_err++; $display("FAIL lb_wb: got we=%b wa=%0d wd=%h want 1/3/ffffff80", we_out, waddr_out, wdata_out); end
    drive(7'b0000011, 3'b100, 5'd4, 32'h10, 32'h0, 1'b1);
    wait_done(cyc, ok);
    @(negedge clk);
    n_vec++; if ({ok, waddr_out, wdata_out} !== {1'b1, 5'd4, 32'h00000080})
      begin n_err++; $display("FAIL lbu_wb: got ok=%b wa=%0d wd=%h want 1/4/00000080", ok, waddr_out, wdata_out); end
    drive(7'b0000011, 3'b001, 5'd8, 32'h12, 32'h0, 1'b1);
    wait_done(cyc, ok);
    @(negedge clk);
    n_vec++; if ({ok, waddr_out, wdata_out} !== {1'b1, 5'd8, 32'hFFFF9234})
      begin n_err++; $display("FAIL lh_wb: got ok=%b wa=%0d wd=%h want 1/8/ffff9234", ok, waddr_out, wdata_out); end
    drive(7'b0000011, 3'b101, 5'd8, 32'h12, 32'h0, 1'b1);
    wait_done(cyc, ok);
    @(negedge clk);
    n_vec++; if ({ok, wdata_out} !== {1'b1, 32'h00009234})
      begin n_err++; $display("FAIL lhu_wb: got ok=%b wd=%h want 1/00009234", ok, wdata_out); end
  endtask

  task automatic test_sh();
    int cyc; bit ok;
    mem[10'h020] = 8'h00; mem[10'h021] = 8'h00; mem[10'h022] = 8'h5A;
    ack_delay = 1;
    req_cnt   = 0;
    drive(7'b0100011, 3'b001, 5'd6, 32'h20, 32'hAABBCCDD, 1'b0);
    wait_done(cyc, ok);
    n_vec++; if (!ok || cyc != 4) begin n_err++; $display("FAIL sh_len: got ok=%b cycles=%0d want 4", ok, cyc); end
    @(negedge clk);
    n_vec++; if (we_out !== 1'b0) begin n_err++; $display("FAIL sh_we_out: got %b want 0", we_out); end
    n_vec++; if ({mem[10'h020], mem[10'h021], mem[10'h022]} !== 24'hDDCC5A)
      begin n_err++; $display("FAIL sh_data: got %h%h%h want ddcc5a", mem[10'h020], mem[10'h021], mem[10'h022]); end
    n_vec++; if (req_cnt != 2 || log_we[0] !== 1'b1 || log_we[1] !== 1'b1 || log_addr[1] !== 32'h21)
      begin n_err++; $display("FAIL sh_reqs: got n=%0d we=%b%b a1=%h want 2/11/00000021", req_cnt, log_we[0], log_we[1], log_addr[1]); end
  endtask

  task automatic test_rdy_stall();
    int cyc; bit ok;
    logic [31:0] a0;
    mem[10'h200] = 8'hEF; mem[10'h201] = 8'hBE; mem[10'h202] = 8'hAD; mem[10'h203] = 8'hDE;
    ack_delay = 3;
    req_cnt   = 0;
    drive(7'b0000011, 3'b010, 5'd12, 32'h200, 32'h0, 1'b1);
    repeat (5) @(negedge clk);
    rdy = 1'b0;
    #2;
    a0 = mem_addr;
    n_vec++; if (a0 !== 32'h201) begin n_err++; $display("FAIL rdy_addr0: got %h want 00000201", a0); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2;
      n_vec++;
      if ({mem_req, stall_req, mem_addr} !== {2'b11, a0})
        begin n_err++; $display("FAIL rdy_hold%0d: got req=%b stall=%b a=%h want 1/1/%h", i, mem_req, stall_req, mem_addr, a0); end
    end
    @(negedge clk);
    rdy = 1'b1;
    wait_done(cyc, ok);
    n_vec++; if (!ok || req_cnt != 4) begin n_err++; $display("FAIL rdy_reqs: got ok=%b n=%0d want 1/4", ok, req_cnt); end
    @(negedge clk);
    n_vec++; if ({we_out, waddr_out, wdata_out} !== {1'b1, 5'd12, 32'hDEADBEEF})
      begin n_err++; $display("FAIL rdy_wb: got we=%b wa=%0d wd=%h want 1/12/deadbeef", we_out, waddr_out, wdata_out); end
  endtask

  // Reserved funct3 011 is a word access; the address wraps past 2^32.
  task automatic test_wrap();
    int cyc; bit ok;
    mem[10'h3FE] = 8'h11; mem[10'h3FF] = 8'h22; mem[10'h000] = 8'h33; mem[10'h001] = 8'h44;
    ack_delay = 0;
    req_cnt   = 0;
    drive(7'b0000011, 3'b011, 5'd2, 32'hFFFFFFFE, 32'h0, 1'b1);
    wait_done(cyc, ok);
    n_vec++; if (!ok || cyc != 4 || req_cnt != 4) begin n_err++; $display("FAIL wrap_len: got ok=%b cycles=%0d n=%0d want 4/4", ok, cyc, req_cnt); end
    n_vec++; if ({log_addr[1], log_addr[2], log_addr[3]} !== {32'hFFFFFFFF, 32'h0, 32'h1})
      begin n_err++; $display("FAIL wrap_addr: got %h %h %h want ffffffff 00000000 00000001", log_addr[1], log_addr[2], log_addr[3]); end
    @(negedge clk);
    n_vec++; if (wdata_out !== 32'h44332211) begin n_err++; $display("FAIL wrap_wb: got %h want 44332211", wdata_out); end
  endtask

  task automatic test_reset_busy();
    ack_delay = 1;
    drive(7'b0000011, 3'b010, 5'd9, 32'h100, 32'h0, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    n_vec++; if ({mem_req, stall_req} !== 2'b11) begin n_err++; $display("FAIL rbusy_pre: got req=%b stall=%b want 1/1", mem_req, stall_req); end
    drive_nop();
    #1 rst = 1'b1;
    #1;
    n_vec++; if ({mem_req, stall_req, mem_addr} !== 34'h0)
      begin n_err++; $display("FAIL rbusy_async: got req=%b stall=%b a=%h want 0/0/0", mem_req, stall_req, mem_addr); end
    @(negedge clk);
    rst = 1'b0;
    drive(7'b0110011, 3'b000, 5'd11, 32'hCAFE, 32'h0, 1'b1);
    @(negedge clk);
    n_vec++; if ({we_out, waddr_out, wdata_out, mem_req, stall_req} !== {1'b1, 5'd11, 32'hCAFE, 2'b00})
      begin n_err++; $display("FAIL rbusy_alu: got we=%b wa=%0d wd=%h req=%b stall=%b want 1/11/0000cafe/0/0",
                              we_out, waddr_out, wdata_out, mem_req, stall_req); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    test_reset();
    test_alu();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_rdy_stall();
    test_wrap();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
